seq_linear_layer: RTL and testbench
===================================

SEQ_LINEAR_LAYER -- requirements
Module: seq_linear_layer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed two's-complement width of every input, weight and output element.
REQ-002 SHALL have parameter NIN, default 4, input vector length (>=1).
REQ-003 SHALL have parameter NOUT, default 3, output vector length (>=1).
REQ-004 SHALL have parameter FRAC_BITS, default 8, arithmetic right shift applied to each accumulator before saturation (0..2*WIDTH-1).
REQ-005 SHALL have parameter WEIGHTS_MATRIX_FLAT, width WIDTH*NIN*NOUT, default 0, signed weights with W[r][c] at bits [(NIN*NOUT-(r*NIN+c))*WIDTH-1 -: WIDTH] (row 0 in MSBs).
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid  input  1  in_vec holds a valid vector.
REQ-009 SHALL have port in_ready  output  1  block can accept a vector.
REQ-010 SHALL have port in_vec  input  WIDTH*NIN  element i at bits [(NIN-i)*WIDTH-1 -: WIDTH].
REQ-011 SHALL have port out_valid  output  1  out_vec holds a result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_vec.
REQ-013 SHALL have port out_vec  output  WIDTH*NOUT  element r at bits [(NOUT-r)*WIDTH-1 -: WIDTH].
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready SHALL register in_vec, clear all NOUT accumulators, clear index k, go ACC.
REQ-017 ACC: each cycle every lane r SHALL add W[r][k]*x[k] (full-precision signed product) to its accumulator; k increments; after k=NIN-1 go DONE.
REQ-018 Accumulator width SHALL be ACC_W = 2*WIDTH + $clog2(NIN) + 1; no accumulator overflow possible.
REQ-019 On ACC->DONE SHALL register out_vec[r] = saturate(acc[r] >>> FRAC_BITS) to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; shift is arithmetic (floor rounding).
REQ-020 DONE: out_valid=1, out_vec stable until out_valid&&out_ready; then go IDLE next cycle.
REQ-021 Latency: vector accepted at edge T SHALL produce out_valid high after edge T+NIN; in_ready returns one cycle after output handshake.
REQ-022 in_ready SHALL be 0 in ACC and DONE; in_valid in those states SHALL be ignored and in_vec not sampled.
REQ-023 out_ready while out_valid=0 SHALL have no effect; NIN=1 SHALL spend exactly one cycle in ACC.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, in_ready=1 after release, out_valid=0, busy=0, out_vec=0, k=0, accumulators=0.
REQ-025 Reset mid-ACC or mid-DONE SHALL discard the in-flight vector with no output handshake.

Configuration
REQ-026 With macro SEQ_LINEAR_RELU_EN defined, each out_vec element SHALL be max(0, saturated value); without it outputs are signed saturated values unchanged.

Structure
REQ-027 Package seq_linear_pkg SHALL hold the FSM state enum (IDLE, ACC, DONE) and a saturation function sized by parameters.
REQ-028 One sub-module linear_mac_lane SHALL implement one lane (accumulator, shift, saturate, optional ReLU), instantiated NOUT times in a generate loop named gen_lane.

Verification
REQ-029 Defaults, weights rows {3000,7808,-2560,-77},{308,-788,-250,-779},{-3072,7808,-2560,-747}, in {-200,35,77,-256}, FRAC_BITS=8 -> out {-1970,355,3444}, out_valid 4 cycles after accept.
REQ-030 Same with FRAC_BITS=0 -> out {-32768,32767,32767} (saturation both signs).
REQ-031 Same as REQ-029 with SEQ_LINEAR_RELU_EN -> out {0,355,3444}.
REQ-032 out_ready held low 10 cycles in DONE, in_valid pulsed with new data -> out_vec unchanged, in_ready 0, new vector not taken.
REQ-033 rst_n asserted at second ACC cycle -> out_valid 0, busy 0 immediately; next vector yields correct result from clean accumulators.
REQ-034 Back-to-back: in_valid held high, out_ready held high, 3 vectors -> 3 results in order, each NIN+2 cycles apart.

Source files
------------

// File: rtl/seq_linear_pkg.sv
// Shared types and helpers for the sequential linear layer.
// Optional feature macro: SEQ_LINEAR_RELU_EN (clamps lane outputs at zero).
package seq_linear_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest value the saturation helper handles; lanes sign-extend into it.
  localparam int SAT_MAX_W = 128;

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          width
  );
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    max_v = (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    min_v = ~max_v;
    if (value > max_v)
      saturate = max_v;
    else if (value < min_v)
      saturate = min_v;
    else
      saturate = value;
  endfunction

endpackage

// File: rtl/linear_mac_lane.sv
// One output lane: multiply-accumulate over the input vector, then
// shift, saturate and (with SEQ_LINEAR_RELU_EN) clamp negatives to zero.
module linear_mac_lane
  import seq_linear_pkg::*;
#(
  parameter int                    WIDTH       = 16,
  parameter int                    NIN         = 4,
  parameter int                    FRAC_BITS   = 8,
  parameter int                    ACC_W       = 2*WIDTH + 3,
  parameter int                    KW          = 2,
  parameter logic [WIDTH*NIN-1:0]  ROW_WEIGHTS = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic                    load,
  input  logic [KW-1:0]           k,
  input  logic signed [WIDTH-1:0] x,
  output logic [WIDTH-1:0]        y
);

  logic signed [WIDTH-1:0]     w_arr [NIN];
  logic signed [WIDTH-1:0]     w_k;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_W-1:0]     acc_reg;
  logic signed [ACC_W-1:0]     acc_next;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [SAT_MAX_W-1:0] wide;
  logic signed [SAT_MAX_W-1:0] sat_wide;
  logic [WIDTH-1:0]            y_next;

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : gen_weight
      assign w_arr[gi] = ROW_WEIGHTS[(NIN-gi)*WIDTH-1 -: WIDTH];
    end
  endgenerate

  assign w_k      = w_arr[k];
  assign prod     = w_k * x;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  // The final product is folded in combinationally so the result can be
  // registered on the same edge that leaves ACC.
  assign acc_next = acc_reg + prod_ext;
  assign shifted  = acc_next >>> FRAC_BITS;
  assign wide     = {{(SAT_MAX_W-ACC_W){shifted[ACC_W-1]}}, shifted};
  assign sat_wide = saturate(wide, WIDTH);

`ifdef SEQ_LINEAR_RELU_EN
  assign y_next = sat_wide[WIDTH-1] ? '0 : sat_wide[WIDTH-1:0];
`else
  assign y_next = sat_wide[WIDTH-1:0];
`endif

  // Accumulator: cleared on vector accept, one product added per ACC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_reg <= '0;
    else if (clr)
      acc_reg <= '0;
    else if (acc_en)
      acc_reg <= acc_next;
  end

  // Output register: captured on the last ACC cycle, held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      y <= '0;
    else if (load)
      y <= y_next;
  end

endmodule

// File: rtl/seq_linear_layer.sv
// Sequential matrix-vector layer: one input element per cycle across NOUT
// parallel lanes. Optional macro SEQ_LINEAR_RELU_EN adds ReLU to outputs.
module seq_linear_layer
  import seq_linear_pkg::*;
#(
  parameter int                          WIDTH               = 16,
  parameter int                          NIN                 = 4,
  parameter int                          NOUT                = 3,
  parameter int                          FRAC_BITS           = 8,
  parameter logic [WIDTH*NIN*NOUT-1:0]   WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*NIN-1:0]   in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*NOUT-1:0]  out_vec,
  output logic                   busy
);

  localparam int ACC_W = 2*WIDTH + $clog2(NIN) + 1;
  localparam int KW    = (NIN > 1) ? $clog2(NIN) : 1;

  state_t                  state_reg, state_next;
  logic [KW-1:0]           k_reg, k_next;
  logic [WIDTH*NIN-1:0]    x_reg, x_next;
  logic signed [WIDTH-1:0] x_arr [NIN];
  logic signed [WIDTH-1:0] x_k;
  logic                    accept;
  logic                    acc_en;
  logic                    last;

  // State, index and captured input vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      x_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      x_reg     <= x_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    x_next     = x_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    acc_en     = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept     = 1'b1;
          x_next     = in_vec;
          k_next     = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        k_next = k_reg + 1'b1;
        if (k_reg == KW'(NIN - 1)) begin
          last       = 1'b1;
          k_next     = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : gen_x
      assign x_arr[gi] = x_reg[(NIN-gi)*WIDTH-1 -: WIDTH];
    end
  endgenerate

  assign x_k = x_arr[k_reg];

  generate
    for (gi = 0; gi < NOUT; gi++) begin : gen_lane
      linear_mac_lane #(
        .WIDTH       (WIDTH),
        .NIN         (NIN),
        .FRAC_BITS   (FRAC_BITS),
        .ACC_W       (ACC_W),
        .KW          (KW),
        .ROW_WEIGHTS (WEIGHTS_MATRIX_FLAT[(NOUT-gi)*NIN*WIDTH-1 -: NIN*WIDTH])
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .acc_en (acc_en),
        .load   (last),
        .k      (k_reg),
        .x      (x_k),
        .y      (out_vec[(NOUT-gi)*WIDTH-1 -: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_seq_linear_layer.sv
// Bench for seq_linear_layer: two instances (FRAC_BITS=8 and FRAC_BITS=0)
// share stimulus; a scoreboard holds model results for each.
module tb_seq_linear_layer;

  localparam logic [191:0] WFLAT = {
    16'sd3000,  16'sd7808, -16'sd2560, -16'sd77,
    16'sd308,  -16'sd788,  -16'sd250,  -16'sd779,
    -16'sd3072, 16'sd7808, -16'sd2560, -16'sd747
  };

  int wm [3][4] = '{'{3000, 7808, -2560, -77},
                    '{308, -788, -250, -779},
                    '{-3072, 7808, -2560, -747}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_vec;
  logic        in_ready, out_valid, busy;
  logic [47:0] out_vec;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [47:0] out_vec_b;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [47:0] q_a [$];
  logic [47:0] q_b [$];
  int          hs_times [$];

  seq_linear_layer #(
    .WIDTH(16), .NIN(4), .NOUT(3), .FRAC_BITS(8), .WEIGHTS_MATRIX_FLAT(WFLAT)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .busy(busy)
  );

  seq_linear_layer #(
    .WIDTH(16), .NIN(4), .NOUT(3), .FRAC_BITS(0), .WEIGHTS_MATRIX_FLAT(WFLAT)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_vec(in_vec), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_vec(out_vec_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    pack4 = {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  // Reference: integer matrix-vector product, floor shift, clamp, optional ReLU.
  function automatic logic [47:0] model(input logic [63:0] v, input int frac);
    logic [47:0] r;
    longint acc, s;
    r = '0;
    for (int row = 0; row < 3; row++) begin
      acc = 0;
      for (int c = 0; c < 4; c++)
        acc += longint'(wm[row][c]) * longint'($signed(v[(4-c)*16-1 -: 16]));
      s = acc >>> frac;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`ifdef SEQ_LINEAR_RELU_EN
      if (s < 0) s = 0;
`endif
      r[(3-row)*16-1 -: 16] = s[15:0];
    end
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (in_valid && in_ready) begin
        q_a.push_back(model(in_vec, 8));
        q_b.push_back(model(in_vec, 0));
      end
      if (out_valid && out_ready) begin
        hs_times.push_back(cycle);
        total++;
        if (q_a.size() == 0) begin
          bad++;
          $display("FAIL sb_a: unexpected output %h, no result required", out_vec);
        end else begin
          logic [47:0] e;
          e = q_a.pop_front();
          if (out_vec !== e) begin
            bad++;
            $display("FAIL sb_a: got %h required %h", out_vec, e);
          end else
            $display("result a: %h ok", out_vec);
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (q_b.size() == 0) begin
          bad++;
          $display("FAIL sb_b: unexpected output %h, no result required", out_vec_b);
        end else begin
          logic [47:0] e;
          e = q_b.pop_front();
          if (out_vec_b !== e) begin
            bad++;
            $display("FAIL sb_b: got %h required %h", out_vec_b, e);
          end else
            $display("result b: %h ok", out_vec_b);
        end
      end
    end
  end

  task automatic send(input logic [63:0] v);
    bit ok;
    ok = 1'b0;
    in_vec   = v;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_accept: in_ready never seen, required 1");
    end
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_out: out_valid timeout after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (out_vec !== 48'h0)  begin bad++; $display("FAIL rst_out_vec: got %h required 0", out_vec); end
    if (out_vec_b !== 48'h0) begin bad++; $display("FAIL rst_out_vec_b: got %h required 0", out_vec_b); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    $display("reset: checked");
  endtask

  task automatic test_spec_vector();
    int lat;
    logic [47:0] exp_a;
`ifdef SEQ_LINEAR_RELU_EN
    exp_a = {16'sd0, 16'sd355, 16'sd3444};
`else
    exp_a = {-16'sd1970, 16'sd355, 16'sd3444};
`endif
    out_ready = 1'b1;
    send(pack4(-200, 35, 77, -256));
    total += 2;
    if (busy !== 1'b1)     begin bad++; $display("FAIL acc_busy: got %b required 1", busy); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL acc_in_ready: got %b required 0", in_ready); end
    wait_out(lat);
    total += 3;
    if (lat != 4)           begin bad++; $display("FAIL latency: got %0d required 4", lat); end
    if (out_vec !== exp_a)  begin bad++; $display("FAIL spec_frac8: got %h required %h", out_vec, exp_a); end
    if (out_vec_b !== {16'h8000, 16'h7fff, 16'h7fff})
      begin bad++; $display("FAIL spec_frac0_sat: got %h required 80007fff7fff", out_vec_b); end
    @(posedge clk); #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_hs_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL post_hs_ready: got %b required 1", in_ready); end
    $display("spec vector: latency %0d out %h", lat, out_vec);
  endtask

  task automatic test_patterns();
    logic [63:0] vecs [6];
    int lat;
    vecs[0] = pack4(-32768, 32767, -32768, 32767);
    vecs[1] = pack4(32767, 32767, 32767, 32767);
    vecs[2] = pack4(0, 0, 0, 0);
    vecs[3] = pack4(1, -1, 256, -256);
    vecs[4] = {$urandom, $urandom};
    vecs[5] = {$urandom, $urandom};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i]);
      wait_out(lat);
      @(posedge clk); #1;
    end
    $display("patterns: 6 vectors sent");
  endtask

  task automatic test_stall();
    logic [63:0] v;
    logic [47:0] e;
    int lat;
    v = pack4(123, -4567, 890, 32000);
    e = model(v, 8);
    out_ready = 1'b0;
    send(v);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      in_vec   = {$urandom, $urandom};
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      total += 3;
      if (in_ready !== 1'b0)  begin bad++; $display("FAIL stall_in_ready: cycle %0d got %b required 0", i, in_ready); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid: cycle %0d got %b required 1", i, out_valid); end
      if (out_vec !== e)      begin bad++; $display("FAIL stall_out_vec: cycle %0d got %h required %h", i, out_vec, e); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL stall_release_ready: got %b required 1", in_ready); end
    $display("stall: 10 cycles held, out %h", e);
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    send(pack4(1000, 2000, 3000, 4000));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(pack4(-7, 300, -32768, 5));
    wait_out(lat);
    total++;
    if (lat != 4) begin bad++; $display("FAIL mid_rst_latency: got %0d required 4", lat); end
    @(posedge clk); #1;
    $display("reset mid-ACC: latency %0d", lat);
  endtask

  task automatic test_back_to_back();
    logic [63:0] vecs [3];
    int idx;
    vecs[0] = pack4(11, -22, 33, -44);
    vecs[1] = pack4(-1000, 500, 250, -125);
    vecs[2] = pack4(20000, -20000, 10000, -10000);
    hs_times.delete();
    out_ready = 1'b1;
    idx       = 0;
    in_vec    = vecs[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 100 && hs_times.size() < 3; c++) begin
      @(negedge clk);
      if (in_ready && in_valid) idx++;
      @(posedge clk); #1;
      if (idx < 3) in_vec = vecs[idx];
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (hs_times.size() != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d results required 3", hs_times.size());
    end else begin
      total += 2;
      if (hs_times[1] - hs_times[0] != 6)
        begin bad++; $display("FAIL b2b_gap1: got %0d required 6", hs_times[1] - hs_times[0]); end
      if (hs_times[2] - hs_times[1] != 6)
        begin bad++; $display("FAIL b2b_gap2: got %0d required 6", hs_times[2] - hs_times[1]); end
      $display("back-to-back: gaps %0d %0d", hs_times[1] - hs_times[0], hs_times[2] - hs_times[1]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_patterns();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d/%0d pending required 0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
